spi_tx_seq: RTL



---
 rtl/spi_tx_seq_pkg.sv | 19 +
 rtl/spi_tx_seq_if.sv | 25 ++
 rtl/spi_tx_seq_byte_fifo.sv | 51 +++++
 rtl/spi_tx_seq.sv | 129 ++++++++++++
 4 files changed

// File: rtl/spi_tx_seq_pkg.sv
// Shared types and constants for the spi_tx_seq byte sequencer.
package spi_tx_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  typedef struct packed {
    logic       dc;
    logic [7:0] dat;
  } entry_t;

  localparam int   ENTRY_W  = $bits(entry_t);
  localparam logic CS_N_RST = 1'b1;

endpackage

// File: rtl/spi_tx_seq_if.sv
// System-side push port plus the spi byte-transmitter and peripheral lines.
interface spi_tx_seq_if;
  logic       wr_en;
  logic [7:0] wr_dat;
  logic       wr_dc;
  logic       full;
  logic       empty;
  logic       ovf;
  logic       busy;
  logic       spi_en;
  logic [7:0] spi_dat;
  logic       spi_done;
  logic       cs_n;
  logic       dc;

  modport master (
    output wr_en, wr_dat, wr_dc, spi_done,
    input  full, empty, ovf, busy, spi_en, spi_dat, cs_n, dc
  );

  modport slave (
    input  wr_en, wr_dat, wr_dc, spi_done,
    output full, empty, ovf, busy, spi_en, spi_dat, cs_n, dc
  );
endinterface

// File: rtl/spi_tx_seq_byte_fifo.sv
// Synchronous FIFO with registered full/empty; head entry always visible on rd_dat.
module byte_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_dat,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic             do_push, do_pop;

  // Full is judged on the registered flag, so a same-cycle pop never makes room.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_dat  = mem[rd_ptr[AW-1:0]];

  always_comb begin
    wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, do_push};
    rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      full   <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
      empty  <= (wr_ptr_nxt == rd_ptr_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wr_dat;
    end
  end
endmodule

// File: rtl/spi_tx_seq.sv
// Feeds buffered {dc, byte} pairs to the spi transmitter one at a time and
// owns chip-select and the data/command line for the peripheral.
module spi_tx_seq
  import spi_tx_seq_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int GAP_CYC = 2
) (
  input logic         clk,
  input logic         rst,
  spi_tx_seq_if.slave bus
);
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYC - 1);

  state_t     state, state_nxt;
  entry_t     head, wr_entry;
  logic       fifo_full, fifo_empty, pop;
  logic [7:0] gap_cnt, gap_cnt_nxt;
  logic       cs_n_reg, cs_n_nxt, spi_en_reg, spi_en_nxt, dc_reg, dc_nxt;
  logic [7:0] spi_dat_reg, spi_dat_nxt;
  logic       busy_reg, ovf_reg;

  assign wr_entry = {bus.wr_dc, bus.wr_dat};

  byte_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (bus.wr_en),
    .pop    (pop),
    .wr_dat (wr_entry),
    .rd_dat (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = fifo_empty ? ST_IDLE : ST_SETUP;
      ST_SETUP: state_nxt = ST_XFER;
      ST_XFER:  state_nxt = bus.spi_done ? ST_GAP : ST_XFER;
      ST_GAP: begin
        if (gap_cnt == 8'd0) state_nxt = fifo_empty ? ST_IDLE : ST_SETUP;
        else                 state_nxt = ST_GAP;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // spi_dat/dc only move on a pop, so they settle a cycle before spi_en rises.
  always_comb begin
    pop         = 1'b0;
    cs_n_nxt    = cs_n_reg;
    spi_en_nxt  = spi_en_reg;
    spi_dat_nxt = spi_dat_reg;
    dc_nxt      = dc_reg;
    gap_cnt_nxt = gap_cnt;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          spi_dat_nxt = head.dat;
          dc_nxt      = head.dc;
          cs_n_nxt    = 1'b0;
        end else begin
          cs_n_nxt    = 1'b1;
        end
      end
      ST_SETUP: spi_en_nxt = 1'b1;
      ST_XFER: begin
        if (bus.spi_done) begin
          spi_en_nxt  = 1'b0;
          gap_cnt_nxt = GAP_LOAD;
        end else begin
          spi_en_nxt  = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt != 8'd0) begin
          gap_cnt_nxt = gap_cnt - 8'd1;
        end else if (!fifo_empty) begin
          pop         = 1'b1;
          spi_dat_nxt = head.dat;
          dc_nxt      = head.dc;
        end else begin
          cs_n_nxt    = 1'b1;
        end
      end
      default: begin
        spi_en_nxt = 1'b0;
        cs_n_nxt   = CS_N_RST;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_n_reg    <= CS_N_RST;
      spi_en_reg  <= 1'b0;
      spi_dat_reg <= 8'h00;
      dc_reg      <= 1'b0;
      gap_cnt     <= 8'd0;
      busy_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      cs_n_reg    <= cs_n_nxt;
      spi_en_reg  <= spi_en_nxt;
      spi_dat_reg <= spi_dat_nxt;
      dc_reg      <= dc_nxt;
      gap_cnt     <= gap_cnt_nxt;
      busy_reg    <= (state_nxt != ST_IDLE);
      ovf_reg     <= bus.wr_en && fifo_full;
    end
  end

  assign bus.cs_n    = cs_n_reg;
  assign bus.spi_en  = spi_en_reg;
  assign bus.spi_dat = spi_dat_reg;
  assign bus.dc      = dc_reg;
  assign bus.busy    = busy_reg;
  assign bus.ovf     = ovf_reg;
  assign bus.full    = fifo_full;
  assign bus.empty   = fifo_empty;
endmodule
